// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// Queue entries carry the full word address; the top slices it down.
package dsram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  localparam int IDX_W = 30;
  localparam int AGE_W = 8;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
    logic [IDX_W-1:0] index;
    logic [AGE_W-1:0] age;
  } dsram_entry_t;

endpackage

// File: rtl/dsram_req_fifo.sv
// In-order request queue with per-entry countdown to readiness.
// The pushed entry arrives with its age already loaded.
module dsram_req_fifo
  import dsram_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  dsram_entry_t push_entry,
  input  logic         pop,
  output dsram_entry_t head,
  output logic         head_ready,
  output logic [PW:0]  count
);

  dsram_entry_t   slot [DEPTH];
  logic [PW-1:0]  wp;
  logic [PW-1:0]  rp;

  // pointers wrap naturally; occupancy tracks push minus pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // store new entries, count every age down to zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wp == PW'(i))
        slot[i] <= push_entry;
      else if (slot[i].age != '0)
        slot[i].age <= slot[i].age - 1'b1;
    end
  end

  assign head       = slot[rp];
  assign head_ready = (count != '0) && (head.age == '0);

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM slave: queued requests, fixed minimum latency.
// DSRAM_RAND_STALL_EN adds LFSR-driven accept/retire stalls.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_INIT =
    AGE_W'(LATENCY - 1);

  logic [31:0]       ram [2**MEM_AW];
  dsram_entry_t      new_entry;
  dsram_entry_t      head;
  logic              head_ready;
  logic              push;
  logic              retire;
  logic              stall_acc;
  logic              stall_ret;
  logic [PW:0]       count;
  logic [MEM_AW-1:0] widx;
  logic              unused_bits;

`ifdef DSRAM_RAND_STALL_EN
  logic [7:0] lfsr;

  // free-running pattern that decides stall cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_acc = lfsr[0];
  assign stall_ret = lfsr[1];
`else
  assign stall_acc = 1'b0;
  assign stall_ret = 1'b0;
`endif

  assign data_sram_addr_ok = (count != FULL) && !stall_acc;
  assign push   = data_sram_req && data_sram_addr_ok;
  assign retire = head_ready && !stall_ret;
  assign widx   = head.index[MEM_AW-1:0];

  // snapshot of the request as it enters the queue
  always_comb begin
    new_entry       = '0;
    new_entry.wr    = data_sram_wr;
    new_entry.size  = data_sram_size;
    new_entry.wstrb = data_sram_wstrb;
    new_entry.wdata = data_sram_wdata;
    new_entry.index = data_sram_addr[31:2];
    new_entry.age   = AGE_INIT;
  end

  dsram_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (new_entry),
    .pop        (retire),
    .head       (head),
    .head_ready (head_ready),
    .count      (count)
  );

  // writes land in the RAM only when they retire
  always_ff @(posedge clk) begin
    if (retire && head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head.wstrb[b])
          ram[widx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

  // registered response; rdata holds between pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
    end else begin
      data_sram_data_ok <= retire;
      if (retire)
        data_sram_rdata <= head.wr ? '0 : ram[widx];
    end
  end

  assign unused_bits = ^{data_sram_addr[1:0], head.size,
                         head.age, head.index};

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: queue-based reference model,
// directed cases plus randomized traffic.
module tb_data_sram_responder;

  localparam int DEP = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  logic        s_req = 1'b0;
  logic        s_wr = 1'b1;
  logic [1:0]  s_size = 2'd2;
  logic [31:0] s_addr = '0;
  logic [3:0]  s_wstrb = 4'hF;
  logic [31:0] s_wdata = '0;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wstrb   (wstrb),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  data_sram_responder #(
    .MEM_AW (12), .DEPTH (4), .LATENCY (6)
  ) dut_slow (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (s_req),
    .data_sram_wr      (s_wr),
    .data_sram_size    (s_size),
    .data_sram_addr    (s_addr),
    .data_sram_wstrb   (s_wstrb),
    .data_sram_wdata   (s_wdata),
    .data_sram_addr_ok (s_addr_ok),
    .data_sram_data_ok (s_data_ok),
    .data_sram_rdata   (s_rdata)
  );

  typedef struct {
    bit        wr;
    bit [3:0]  strb;
    bit [31:0] data;
    int        idx;
    int        acc;
    int        due;
  } txn_t;

  txn_t        q[$];
  bit [31:0]   mm[int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dok_cnt = 0;
  int          last_lat = 0;
  int          last_resp = 0;
  int          prev_resp = 0;
  int          stall_seen = 0;
  int          s_resp = 0;
  int          s_first = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] last_read = '0;
  txn_t        t;
  txn_t        n;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old,
                                      input bit [31:0] d,
                                      input bit [3:0] s);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // outputs after edge cyc, then the request for edge cyc+1
  always @(negedge clk) begin
    if (data_ok) dok_cnt++;
    if (s_data_ok) begin
      if (s_resp == 0) s_first = cyc;
      s_resp++;
      chk("slow_wr_rdata", s_rdata, 32'h0);
    end
    if (!resetn) begin
      chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
      q.delete();
      last_rd = '0;
    end else begin
      if (data_ok) begin
        if (q.size() == 0) begin
          chk("spurious_data_ok", {31'd0, data_ok}, 32'd0);
        end else begin
          t = q.pop_front();
          last_lat  = cyc - t.acc;
          prev_resp = last_resp;
          last_resp = cyc;
`ifndef DSRAM_RAND_STALL_EN
          chk("resp_cycle", cyc, t.due);
`else
          chk("resp_not_early", {31'd0, cyc >= t.due}, 32'd1);
`endif
          if (t.wr) begin
            chk("wr_rdata", rdata, 32'h0);
            if (mm.exists(t.idx))
              mm[t.idx] = merge(mm[t.idx], t.data, t.strb);
            else if (t.strb == 4'hF)
              mm[t.idx] = t.data;
            last_rd = '0;
          end else begin
            if (mm.exists(t.idx)) begin
              chk("rd_rdata", rdata, mm[t.idx]);
              last_rd = mm[t.idx];
            end else begin
              last_rd = rdata;
            end
            last_read = rdata;
          end
        end
      end else begin
        chk("rdata_hold", rdata, last_rd);
`ifndef DSRAM_RAND_STALL_EN
        chk("resp_missing",
            {31'd0, q.size() > 0 && q[0].due <= cyc}, 32'd0);
`endif
      end
`ifndef DSRAM_RAND_STALL_EN
      chk("addr_ok", {31'd0, addr_ok},
          {31'd0, q.size() < DEP});
`else
      if (q.size() >= DEP)
        chk("addr_ok_full", {31'd0, addr_ok}, 32'd0);
      if (!addr_ok && q.size() < DEP) stall_seen++;
`endif
      if (req && addr_ok) begin
        n.wr   = wr;
        n.strb = wstrb;
        n.data = wdata;
        n.idx  = int'((addr >> 2) & 32'hFFF);
        n.acc  = cyc + 1;
        n.due  = cyc + 1 + LAT;
        q.push_back(n);
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [3:0] s,
                       input logic [31:0] d);
    bit ok;
    int k;
    ok = 1'b0;
    k = 0;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    while (!ok && k < 50) begin
      @(negedge clk);
      ok = addr_ok;
      @(posedge clk);
      #2;
      k++;
    end
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int c);
    req = 1'b0;
    repeat (c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    req = 1'b0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drain_empty", q.size(), 32'd0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int snap;
    int s_acc;
    int s_low;
    int s_start;
    logic [31:0] ra;
    logic [31:0] up;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_lit_addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("rst_lit_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_lit_rdata", rdata, 32'd0);
    resetn = 1'b1;
    idle(1);

    issue(1'b0, 32'h0, 4'h0, 32'h0);
    drain();
`ifndef DSRAM_RAND_STALL_EN
    chk("first_latency", last_lat, 32'd2);
`endif

    issue(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    drain();
    chk("wr_then_rd", last_read, 32'hDEADBEEF);
`ifndef DSRAM_RAND_STALL_EN
    chk("b2b_resp_gap", last_resp - prev_resp, 32'd1);
`endif

    issue(1'b1, 32'h1002, 4'b0100, 32'h00AA0000);
    issue(1'b0, 32'h1002, 4'h0, 32'h0);
    drain();
    chk("byte_merge", last_read, 32'hDEAABEEF);

    issue(1'b1, 32'h2000, 4'hF, 32'h11111111);
    drain();
    issue(1'b1, 32'h2000, 4'hF, 32'h22222222);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    req = 1'b0;
    resetn = 1'b0;
    snap = dok_cnt;
    idle(2);
    resetn = 1'b1;
    idle(8);
    chk("no_resp_after_reset", dok_cnt - snap, 32'd0);
    issue(1'b0, 32'h2000, 4'h0, 32'h0);
    drain();
    chk("retired_write_kept", last_read, 32'h11111111);

    s_acc = 0;
    s_low = 0;
    s_resp = 0;
    s_start = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      s_req = 1'b1;
      s_addr = 32'(i) << 2;
      s_wdata = 32'(i);
      @(negedge clk);
      if (s_addr_ok) s_acc++;
      else s_low++;
      @(posedge clk);
      #2;
    end
    s_req = 1'b0;
    idle(20);
`ifndef DSRAM_RAND_STALL_EN
    chk("slow_accepts", s_acc, 32'd5);
    chk("slow_addr_ok_low", s_low, 32'd3);
    chk("slow_first_lat", s_first - s_start, 32'd6);
    chk("slow_resp_count", s_resp, 32'd5);
`endif

    snap = dok_cnt;
    for (int i = 0; i < 8; i++)
      issue(1'b1, 32'(i) << 2, 4'hF, $urandom);
    for (int i = 0; i < 100; i++) begin
      up = $urandom;
      ra = (up & 32'hFFFFC000)
         | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), ra,
            4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    chk("rand_resp_count", dok_cnt - snap, 32'd108);
`ifdef DSRAM_RAND_STALL_EN
    chk("stall_seen", {31'd0, stall_seen > 0}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
